// File: rtl/alu_seq.sv
// Sequenced ALU: one-cycle binary ops, nibble-serial BCD add/subtract.
// Optional BCD path is compiled in with `define ALU_SEQ_DECIMAL_EN.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             invert_b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BIN, S_DEC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             cin_q, cin_d, c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c, bin_v;

`ifdef ALU_SEQ_DECIMAL_EN
    logic             inv_q, inv_d, cy_q, cy_d;
    logic [CW-1:0]    nib_q, nib_d;
    logic [WIDTH-5:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_shift;
    logic [4:0]       dsum;
    logic [5:0]       ddif;
    logic [3:0]       dig;
    logic             dcy;
`else
    logic unused_decimal;
    assign unused_decimal = decimal;
`endif

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        bin_res = a_q;
        bin_c   = 1'b0;
        bin_v   = 1'b0;
        case (op_q)
            3'b000: begin
                bin_res = sum[WIDTH-1:0];
                bin_c   = sum[WIDTH];
                bin_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            3'b001: bin_res = a_q & b_q;
            3'b010: bin_res = a_q ^ b_q;
            3'b011: bin_res = a_q | b_q;
            3'b100: begin
                bin_res = {cin_q, a_q[WIDTH-1:1]};
                bin_c   = a_q[0];
            end
            3'b101: begin
                bin_res = {a_q[WIDTH-2:0], cin_q};
                bin_c   = a_q[WIDTH-1];
            end
            default: bin_res = a_q;
        endcase
    end

`ifdef ALU_SEQ_DECIMAL_EN
    // Low nibble of a_q/b_q is always the digit in flight; b_q holds ~b_in when subtracting.
    always_comb begin
        dsum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0, cy_q};
        ddif = {2'b0, a_q[3:0]} - {2'b0, ~b_q[3:0]} - {5'b0, ~cy_q};
        dig  = dsum[3:0];
        dcy  = 1'b0;
        if (!inv_q) begin
            if (dsum > 5'd9) begin
                dig = dsum[3:0] + 4'd6;
                dcy = 1'b1;
            end
        end else if (ddif[5]) begin
            dig = ddif[3:0] + 4'd10;
            dcy = 1'b0;
        end else begin
            dig = ddif[3:0];
            dcy = 1'b1;
        end
        acc_shift = {dig, acc_q};
    end
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cin_d    = cin_q;
        result_d = result_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        done_d   = 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
        inv_d    = inv_q;
        cy_d     = cy_q;
        nib_d    = nib_q;
        acc_d    = acc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = invert_b ? ~b_in : b_in;
                    op_d    = op;
                    cin_d   = carry_in;
                    state_d = S_BIN;
`ifdef ALU_SEQ_DECIMAL_EN
                    inv_d   = invert_b;
                    cy_d    = carry_in;
                    nib_d   = '0;
                    acc_d   = '0;
                    if (op == 3'b000 && decimal) state_d = S_DEC;
`endif
                end
            end
            S_BIN: begin
                result_d = bin_res;
                c_d      = bin_c;
                v_d      = bin_v;
                z_d      = (bin_res == '0);
                n_d      = bin_res[WIDTH-1];
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
`ifdef ALU_SEQ_DECIMAL_EN
            S_DEC: begin
                a_d   = a_q >> 4;
                b_d   = b_q >> 4;
                cy_d  = dcy;
                acc_d = acc_shift[WIDTH-1:4];
                nib_d = nib_q + 1'b1;
                if (nib_q == CW'(NIB - 1)) begin
                    result_d = acc_shift;
                    c_d      = dcy;
                    v_d      = 1'b0;
                    z_d      = (acc_shift == '0);
                    n_d      = acc_shift[WIDTH-1];
                    done_d   = 1'b1;
                    nib_d    = '0;
                    state_d  = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
            inv_q    <= 1'b0;
            cy_q     <= 1'b0;
            nib_q    <= '0;
            acc_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            done_q   <= done_d;
`ifdef ALU_SEQ_DECIMAL_EN
            inv_q    <= inv_d;
            cy_q     <= cy_d;
            nib_q    <= nib_d;
            acc_q    <= acc_d;
`endif
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = c_q;
    assign overflow  = v_q;
    assign zero      = z_q;
    assign negative  = n_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be a multiple of 4, range 8..32.
REQ-002 Derived NIB = WIDTH/4, the number of BCD nibbles.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; sampled only while idle.
REQ-006 op  input  3  000 ADD, 001 AND, 010 EOR, 011 OR, 100 SHR, 101 SHL, 110/111 reserved.
REQ-007 a_in, b_in  input  WIDTH  operands.
REQ-008 invert_b  input  1  b = ~b_in when high (subtract path).
REQ-009 carry_in  input  1  carry/no-borrow in, or shift fill bit.
REQ-010 decimal  input  1  BCD mode for ADD.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 done  output  1  one-cycle pulse when the result registers update.
REQ-013 result  output  WIDTH  registered result.
REQ-014 carry_out, overflow, zero, negative  output  1 each  registered flags.

Function
REQ-015 FSM states: IDLE, BIN, DEC. IDLE->BIN on start when not (op==ADD and decimal); IDLE->DEC on start when op==ADD and decimal.
REQ-016 On the accepting edge, a_in, b (after invert_b), op, carry_in and decimal SHALL be latched; later input changes SHALL have no effect.
REQ-017 BIN SHALL compute the result, update result and flags, pulse done, and return to IDLE on the next edge; done is high 1 cycle after the accept edge.
REQ-018 DEC SHALL process one nibble per edge, LSB nibble first, with a nibble counter 0..NIB-1; after the NIB-th edge it SHALL update result and flags, pulse done, and return to IDLE. Done latency is NIB cycles.
REQ-019 ADD binary: {carry_out,result} = a + b + carry_in (WIDTH+1 bits).
REQ-020 ADD binary overflow = (a[MSB]==b[MSB]) and (result[MSB]!=a[MSB]).
REQ-021 ADD decimal, invert_b=0: per nibble, s = a_n + b_n + c; if s > 9 then s += 6 and c = 1, else c = 0. carry_out is the final c.
REQ-022 ADD decimal, invert_b=1: per nibble, d = a_n - b_in_n - (1-c); if d < 0 then d += 10 and c = 0, else c = 1. carry_out is the final c (1 means no borrow).
REQ-023 Decimal overflow SHALL be 0. Non-BCD nibble inputs give defined but unspecified nibble values, with no X propagation.
REQ-024 AND/EOR/OR: result = a op b; carry_out = 0; overflow = 0.
REQ-025 SHR: result = {carry_in, a[WIDTH-1:1]}; carry_out = a[0]. SHL: result = {a[WIDTH-2:0], carry_in}; carry_out = a[MSB]. overflow = 0.
REQ-026 Reserved ops: result = a; carry_out = 0; overflow = 0.
REQ-027 For every op: zero = (result == 0); negative = result[MSB].
REQ-028 start while busy SHALL be ignored, not queued.
REQ-029 start on the same edge that done is asserted SHALL be ignored; a new start is accepted the cycle after done.
REQ-030 result and flags SHALL hold their values between done pulses.

Reset
REQ-031 rst high at any edge, including mid-DEC, SHALL force IDLE, clear the nibble counter, and zero busy, done, result, carry_out, overflow, zero and negative. The in-flight operation is discarded with no done pulse.
REQ-032 rst SHALL take priority over start on the same edge.

Configuration
REQ-033 Macro ALU_SEQ_DECIMAL_EN: when defined, the DEC state and BCD logic are compiled in as specified above.
REQ-034 When ALU_SEQ_DECIMAL_EN is undefined, the decimal input SHALL be ignored: every op uses BIN with 1-cycle latency, and no DEC logic is synthesised.

Verification (WIDTH=8, macro defined unless noted)
REQ-035 ADD, a=0x45, b=0x2A, cin=0, dec=0 -> done at +1 cycle, result=0x6F, c=0, v=0, z=0, n=0.
REQ-036 ADD, a=0x50, b=0x50, cin=0 -> result=0xA0, v=1, n=1, c=0; separately a=0xFF, b=0x01 -> result=0x00, c=1, z=1.
REQ-037 ADD dec, a=0x58, b=0x46, cin=1 -> done at +2 cycles, result=0x05, c=1; same stimulus with macro undefined -> +1 cycle, result=0x9F, c=0.
REQ-038 ADD dec, invert_b=1, a=0x12, b_in=0x21, cin=1 -> result=0x91, c=0; with a=0x46, b_in=0x12, cin=1 -> result=0x34, c=1.
REQ-039 SHR, a=0x81, cin=1 -> result=0xC0, c=1, n=1; SHL, a=0x81, cin=0 -> result=0x02, c=1.
REQ-040 Decimal start, then start pulsed while busy, then rst after 1 cycle -> no done pulse, all outputs 0, IDLE; the next start is accepted normally.
